// File: rtl/truth_scan_pkg.sv
// rtl/truth_scan_pkg.sv - scanner FSM states, default sizing and compare helper
package truth_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_IN_DEF   = 4;
  localparam int SETTLE_DEF = 1;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [5:0] lowest_set(input logic [63:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) r = 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// rtl/truth_table_scanner_if.sv - scan control, stimulus and result bundle
// Compare signals exist only with TRUTH_SCAN_CMP_EN defined.
interface truth_table_scanner_if #(
  parameter int N_IN = truth_scan_pkg::N_IN_DEF
);
  logic                 start_i;
  logic [N_IN-1:0]      stim_o;
  logic                 f_in_i;
  logic                 busy_o;
  logic                 done_o;
  logic [2**N_IN-1:0]   table_o;
`ifdef TRUTH_SCAN_CMP_EN
  logic [2**N_IN-1:0]   expected_i;
  logic                 match_o;
  logic [N_IN-1:0]      mismatch_idx_o;
`endif

  modport slave (
`ifdef TRUTH_SCAN_CMP_EN
    input  expected_i,
    output match_o, mismatch_idx_o,
`endif
    input  start_i, f_in_i,
    output stim_o, busy_o, done_o, table_o
  );

  modport master (
`ifdef TRUTH_SCAN_CMP_EN
    output expected_i,
    input  match_o, mismatch_idx_o,
`endif
    output start_i, f_in_i,
    input  stim_o, busy_o, done_o, table_o
  );
endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// rtl/truth_table_scanner_settle_timer.sv - holds each stimulus for SETTLE cycles
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == 4'(SETTLE - 1));
endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks every input combination and captures f_in
// Optional expected-table compare enabled by TRUTH_SCAN_CMP_EN.
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  truth_table_scanner_if.slave bus
);
  localparam int              TW       = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [TW-1:0]   table_q, table_d;
  logic            tmr_load, tmr_expire;
`ifdef TRUTH_SCAN_CMP_EN
  logic            match_q, match_d;
  logic [N_IN-1:0] mm_idx_q, mm_idx_d;
`endif

  settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .en_i     (state_q == DRIVE),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    table_d  = table_q;
    tmr_load = 1'b0;
`ifdef TRUTH_SCAN_CMP_EN
    match_d  = match_q;
    mm_idx_d = mm_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d  = DRIVE;
          stim_d   = '0;
          table_d  = '0;
          tmr_load = 1'b1;
`ifdef TRUTH_SCAN_CMP_EN
          match_d  = 1'b0;
          mm_idx_d = '0;
`endif
        end
      end
      DRIVE: begin
        if (tmr_expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        table_d[stim_q] = bus.f_in_i;
        // The all-ones index ends the scan so stim never wraps.
        if (stim_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          stim_d   = stim_q + 1'b1;
          state_d  = DRIVE;
          tmr_load = 1'b1;
        end
      end
      DONE: begin
        stim_d  = '0;
        state_d = IDLE;
`ifdef TRUTH_SCAN_CMP_EN
        match_d  = (table_q == bus.expected_i);
        mm_idx_d = N_IN'(lowest_set(64'(table_q ^ bus.expected_i)));
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stim_q   <= '0;
      table_q  <= '0;
`ifdef TRUTH_SCAN_CMP_EN
      match_q  <= 1'b0;
      mm_idx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      table_q  <= table_d;
`ifdef TRUTH_SCAN_CMP_EN
      match_q  <= match_d;
      mm_idx_q <= mm_idx_d;
`endif
    end
  end

  assign bus.stim_o  = stim_q;
  assign bus.busy_o  = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done_o  = (state_q == DONE);
  assign bus.table_o = table_q;
`ifdef TRUTH_SCAN_CMP_EN
  assign bus.match_o        = match_q;
  assign bus.mismatch_idx_o = mm_idx_q;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - scoreboard bench for truth_table_scanner
// Compare checks active only with TRUTH_SCAN_CMP_EN defined.
module tb_truth_table_scanner;
  typedef struct {
    int          dcyc;
    logic [15:0] tbl;
    logic        mt;
    logic [3:0]  idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit   pend_a = 0;
  bit   pend_b = 0;
  exp_t cur_a, cur_b;
  logic [3:0] s;

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  truth_table_scanner_if #(.N_IN(4)) bus_a ();
  truth_table_scanner_if #(.N_IN(4)) bus_b ();

  truth_table_scanner #(.N_IN(4), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  truth_table_scanner #(.N_IN(4), .SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  // f = AD | ~B~C | ~CD | ~AC~D | BC~D with stim = {A,B,C,D}
  assign s = bus_a.stim_o;
  assign bus_a.f_in_i = (s[3] & s[0]) | (~s[2] & ~s[1]) | (~s[1] & s[0]) |
                        (~s[3] & s[1] & ~s[0]) | (s[2] & s[1] & ~s[0]);
  assign bus_b.f_in_i = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (bus_a.done_o === 1'b1) begin
      chk("a_done_expected", 64'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        cur_a = q_a.pop_front();
        chk("a_done_cycle", 64'(cyc), 64'(cur_a.dcyc));
        chk("a_table", bus_a.table_o, cur_a.tbl);
        pend_a = 1;
      end
    end else if (pend_a) begin
      pend_a = 0;
      chk("a_stim_after_done", bus_a.stim_o, 0);
`ifdef TRUTH_SCAN_CMP_EN
      chk("a_match", bus_a.match_o, cur_a.mt);
      chk("a_mismatch_idx", bus_a.mismatch_idx_o, cur_a.idx);
`endif
    end
    if (bus_b.done_o === 1'b1) begin
      chk("b_done_expected", 64'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        cur_b = q_b.pop_front();
        chk("b_done_cycle", 64'(cyc), 64'(cur_b.dcyc));
        chk("b_table", bus_b.table_o, cur_b.tbl);
        pend_b = 1;
      end
    end else if (pend_b) begin
      pend_b = 0;
      chk("b_stim_after_done", bus_b.stim_o, 0);
`ifdef TRUTH_SCAN_CMP_EN
      chk("b_match", bus_b.match_o, cur_b.mt);
      chk("b_mismatch_idx", bus_b.mismatch_idx_o, cur_b.idx);
`endif
    end
  end

  // Called on a negedge; returns the cycle number of the accepting edge.
  task automatic pulse_a(output int acc);
    bus_a.start_i = 1'b1;
    @(negedge clk);
    bus_a.start_i = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q_a.size() > 0 || q_b.size() > 0 || pend_a || pend_b); i++)
      @(negedge clk);
    chk("drain_a", 64'(q_a.size()), 0);
    chk("drain_b", 64'(q_b.size()), 0);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_stim"},  bus_a.stim_o, 0);
    chk({tag, "_busy"},  bus_a.busy_o, 0);
    chk({tag, "_done"},  bus_a.done_o, 0);
    chk({tag, "_table"}, bus_a.table_o, 0);
`ifdef TRUTH_SCAN_CMP_EN
    chk({tag, "_match"}, bus_a.match_o, 0);
    chk({tag, "_idx"},   bus_a.mismatch_idx_o, 0);
`endif
  endtask

  initial begin
    int acc;
    rst_n = 1'b0;
    bus_a.start_i = 1'b0;
    bus_b.start_i = 1'b0;
`ifdef TRUTH_SCAN_CMP_EN
    bus_a.expected_i = 16'hEB67;
    bus_b.expected_i = 16'hFFFF;
`endif
    repeat (3) @(negedge clk);
    chk_zero_a("reset");
    chk("reset_b_busy", bus_b.busy_o, 0);
    chk("reset_b_table", bus_b.table_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Matching expected table
    pulse_a(acc);
    q_a.push_back('{acc + 32, 16'hEB67, 1'b1, 4'd0});
    chk("a_busy_running", bus_a.busy_o, 1);
    drain();
    repeat (3) @(negedge clk);
    chk("a_table_hold", bus_a.table_o, 16'hEB67);

    // Expected differs in bit 0
`ifdef TRUTH_SCAN_CMP_EN
    bus_a.expected_i = 16'hEB66;
`endif
    pulse_a(acc);
    q_a.push_back('{acc + 32, 16'hEB67, 1'b0, 4'd0});
    drain();

    // Expected differs in bits 5 and 6
`ifdef TRUTH_SCAN_CMP_EN
    bus_a.expected_i = 16'hEB07;
`endif
    pulse_a(acc);
    q_a.push_back('{acc + 32, 16'hEB67, 1'b0, 4'd5});
    drain();

    // Re-pulse mid-scan and during DONE: both ignored
`ifdef TRUTH_SCAN_CMP_EN
    bus_a.expected_i = 16'hEB67;
`endif
    pulse_a(acc);
    q_a.push_back('{acc + 32, 16'hEB67, 1'b1, 4'd0});
    wait_until(acc + 9);
    bus_a.start_i = 1'b1;
    @(negedge clk);
    bus_a.start_i = 1'b0;
    wait_until(acc + 32);
    bus_a.start_i = 1'b1;
    @(negedge clk);
    bus_a.start_i = 1'b0;
    chk("a_start_in_done_ignored", bus_a.busy_o, 0);
    @(negedge clk);
    chk("a_still_idle", bus_a.busy_o, 0);
    drain();

    // Reset mid-scan
    pulse_a(acc);
    wait_until(acc + 12);
    chk("a_partial_table", bus_a.table_o, 16'h0027);
    rst_n = 1'b0;
    #1;
    chk_zero_a("midreset");
    q_a.delete();
    wait_until(acc + 14);
    chk_zero_a("midreset_hold");
    rst_n = 1'b1;
    wait_until(acc + 19);
    q_a.push_back('{acc + 52, 16'hEB67, 1'b1, 4'd0});
    pulse_a(acc);
    drain();

    // SETTLE=3 instance, f_in tied high
    bus_b.start_i = 1'b1;
    @(negedge clk);
    bus_b.start_i = 1'b0;
    acc = cyc;
    q_b.push_back('{acc + 64, 16'hFFFF, 1'b1, 4'd0});
    for (int k = 0; k < 16; k++) begin
      wait_until(acc + 4 * k + 2);
      chk("b_stim_step", bus_b.stim_o, 64'(k));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
